reg_array_loader: RTL and testbench

REG_ARRAY_LOADER -- requirements
Module: reg_array_loader

---
 rtl/reg_array_loader_pkg.sv | 16 +
 rtl/reg_array_param.sv | 30 +++
 rtl/reg_array_loader.sv | 146 ++++++++++++++
 tb/tb_reg_array_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_array_loader_pkg.sv
// Shared definitions for the register-array loader: FSM state encoding and
// completed-word counter sizing.
package reg_array_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_FILL_WR = 3'd3,
        ST_FILL_VF = 3'd4
    } state_e;

    localparam int                    WR_CNT_W   = 8;
    localparam logic [WR_CNT_W-1:0]   WR_CNT_MAX = {WR_CNT_W{1'b1}};

endpackage

// File: rtl/reg_array_param.sv
// Target register array: synchronous write, combinational read on radd,
// cleared by the asynchronous active-low reset.
module reg_array_param #(
    parameter int M = 2,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wrt_enab,
    input  logic [N-1:0] d_in,
    input  logic [M-1:0] radd,
    input  logic [M-1:0] wadd,
    output logic [N-1:0] d_out
);

    logic [N-1:0] mem_q [2**M];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 2**M; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrt_enab) begin
            mem_q[wadd] <= d_in;
        end
    end

    assign d_out = mem_q[radd];

endmodule

// File: rtl/reg_array_loader.sv
// Write-then-verify loader for a register array: single requests or a full
// fill with one pattern, each word read back and compared with a sticky error.
module reg_array_loader
    import reg_array_loader_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M-1:0]        in_addr,
    input  logic [N-1:0]        in_data,
    input  logic                fill_start,
    input  logic [N-1:0]        fill_data,
    input  logic                err_clr,
    output logic                wrt_enab,
    output logic [M-1:0]        wadd,
    output logic [N-1:0]        d_in,
    output logic [M-1:0]        radd,
    input  logic [N-1:0]        d_out,
    output logic                done,
    output logic                err,
    output logic [M-1:0]        err_addr,
    output logic [WR_CNT_W-1:0] wr_count,
    output state_e              dbg_state
);

    // Handshake: a request transfers at a posedge where in_valid and in_ready
    // are both high; in_ready drops while fill_start is asserted in IDLE.

    localparam logic [M-1:0] LAST_ADDR = {M{1'b1}};

    state_e              state_q;
    logic [M-1:0]        addr_q;
    logic [N-1:0]        data_q;
    logic                wrt_enab_q;
    logic [M-1:0]        wadd_q;
    logic [N-1:0]        d_in_q;
    logic [M-1:0]        radd_q;
    logic                done_q;
    logic                err_q, err_d;
    logic [M-1:0]        err_addr_q, err_addr_d;
    logic [WR_CNT_W-1:0] cnt_q, cnt_d;
    logic                verifying;
    logic                mismatch;

    assign verifying = (state_q == ST_VERIFY) || (state_q == ST_FILL_VF);
    assign mismatch  = verifying && (d_out != data_q);

    // A mismatch coinciding with err_clr wins and recaptures the address.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        if (mismatch && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
        if (verifying && (cnt_q != WR_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // addr_q doubles as the fill index while a fill is running.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wrt_enab_q <= 1'b0;
            wadd_q     <= '0;
            d_in_q     <= '0;
            radd_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            wrt_enab_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        state_q    <= ST_FILL_WR;
                        addr_q     <= '0;
                        data_q     <= fill_data;
                        wrt_enab_q <= 1'b1;
                        wadd_q     <= '0;
                        d_in_q     <= fill_data;
                    end else if (in_valid) begin
                        state_q    <= ST_WRITE;
                        addr_q     <= in_addr;
                        data_q     <= in_data;
                        wrt_enab_q <= 1'b1;
                        wadd_q     <= in_addr;
                        d_in_q     <= in_data;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_VERIFY;
                    radd_q  <= addr_q;
                end
                ST_VERIFY: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                ST_FILL_WR: begin
                    state_q <= ST_FILL_VF;
                    radd_q  <= addr_q;
                end
                ST_FILL_VF: begin
                    done_q <= 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q    <= ST_FILL_WR;
                        addr_q     <= addr_q + 1'b1;
                        wrt_enab_q <= 1'b1;
                        wadd_q     <= addr_q + 1'b1;
                        d_in_q     <= data_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !fill_start;
    assign wrt_enab  = wrt_enab_q;
    assign wadd      = wadd_q;
    assign d_in      = d_in_q;
    assign radd      = radd_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign wr_count  = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_array_loader.sv
// Bench for reg_array_loader driving a reg_array_param target, with a
// behavioural model of array contents, sticky error and completed-word count.
module tb_reg_array_loader;
  import reg_array_loader_pkg::*;

  localparam int M = 2;
  localparam int N = 4;
  localparam int WORDS = 1 << M;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [M-1:0] in_addr = '0;
  logic [N-1:0] in_data = '0;
  logic fill_start = 1'b0;
  logic [N-1:0] fill_data = '0;
  logic err_clr = 1'b0;
  logic wrt_enab;
  logic [M-1:0] wadd;
  logic [N-1:0] d_in;
  logic [M-1:0] radd;
  logic [N-1:0] arr_dout;
  logic [N-1:0] d_out;
  logic done;
  logic err;
  logic [M-1:0] err_addr;
  logic [7:0] wr_count;
  state_e dbg_state;

  logic force_en = 1'b0;
  logic [N-1:0] force_val = '0;
  assign d_out = force_en ? force_val : arr_dout;

  int n_tests = 0;
  int n_fail = 0;

  // reference model
  int exp_cnt = 0;
  bit exp_err = 1'b0;
  logic [M-1:0] exp_err_addr = '0;
  logic [N-1:0] mem_model [WORDS];
  logic [N-1:0] exp_q [$];

  // observations from the request driver
  bit hs_ok;
  logic obs_we1, obs_we2, obs_dn2, obs_dn3, obs_rdy3;
  logic [M-1:0] obs_wa1, obs_ra2;
  logic [N-1:0] obs_di1;

  reg_array_loader #(.M(M), .N(N)) u_dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .fill_start(fill_start),
    .fill_data(fill_data), .err_clr(err_clr), .wrt_enab(wrt_enab),
    .wadd(wadd), .d_in(d_in), .radd(radd), .d_out(d_out), .done(done),
    .err(err), .err_addr(err_addr), .wr_count(wr_count), .dbg_state(dbg_state)
  );

  reg_array_param #(.M(M), .N(N)) u_arr (
    .clk(clk), .clr(clr), .wrt_enab(wrt_enab), .d_in(d_in),
    .radd(radd), .wadd(wadd), .d_out(arr_dout)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model: one completed word written with wr and read back as rd
  function automatic void model_op(input logic [M-1:0] a, input logic [N-1:0] wr,
                                   input logic [N-1:0] rd, input bit ec);
    mem_model[a] = wr;
    if (rd != wr && (!exp_err || ec)) begin
      exp_err = 1'b1;
      exp_err_addr = a;
    end else if (ec) begin
      exp_err = 1'b0;
    end
    if (exp_cnt < 255) exp_cnt++;
  endfunction

  function automatic void model_reset();
    exp_cnt = 0;
    exp_err = 1'b0;
    exp_err_addr = '0;
    for (int i = 0; i < WORDS; i++) mem_model[i] = '0;
  endfunction

  // driver: one request; optional forced readback and err_clr during verify
  task automatic run_req(input logic [M-1:0] a, input logic [N-1:0] d, input bit fen,
                         input logic [N-1:0] fv, input bit ec);
    int n;
    n = 0;
    obs_we1 = 'x; obs_we2 = 'x; obs_dn2 = 'x; obs_dn3 = 'x; obs_rdy3 = 'x;
    obs_wa1 = 'x; obs_ra2 = 'x; obs_di1 = 'x;
    in_valid = 1'b1; in_addr = a; in_data = d;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    hs_ok = (in_ready === 1'b1);
    n_tests++;
    if (!hs_ok) begin
      n_fail++;
      $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs_we1 = wrt_enab; obs_wa1 = wadd; obs_di1 = d_in;
    @(posedge clk); #1;
    force_en = fen; force_val = fv; err_clr = ec;
    obs_we2 = wrt_enab; obs_ra2 = radd; obs_dn2 = done;
    @(posedge clk); #1;
    force_en = 1'b0; err_clr = 1'b0;
    obs_dn3 = done; obs_rdy3 = in_ready;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (wrt_enab !== 1'b0) begin n_fail++; $display("FAIL reset_wrt_enab: got %b exp 0", wrt_enab); end
    n_tests++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got done=%b err=%b exp 0/0", done, err); end
    n_tests++; if ({wadd, radd, d_in, err_addr} !== '0) begin n_fail++; $display("FAIL reset_addr_data: got wadd=%h radd=%h d_in=%h err_addr=%h exp 0", wadd, radd, d_in, err_addr); end
    n_tests++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL reset_wr_count: got %0d exp 0", wr_count); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp IDLE", dbg_state); end
    @(posedge clk); #1;
    clr = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_recovery_ready: got %b exp 1", in_ready); end
    model_reset();
  endtask

  task automatic test_single_write();
    run_req(2'd2, 4'hA, 1'b0, '0, 1'b0);
    if (!hs_ok) return;
    model_op(2'd2, 4'hA, 4'hA, 1'b0);
    n_tests++; if (obs_we1 !== 1'b1 || obs_wa1 !== 2'd2 || obs_di1 !== 4'hA) begin n_fail++; $display("FAIL single_write_beat: got we=%b wadd=%h d_in=%h exp 1/2/a", obs_we1, obs_wa1, obs_di1); end
    n_tests++; if (obs_we2 !== 1'b0 || obs_ra2 !== 2'd2 || obs_dn2 !== 1'b0) begin n_fail++; $display("FAIL single_verify_beat: got we=%b radd=%h done=%b exp 0/2/0", obs_we2, obs_ra2, obs_dn2); end
    n_tests++; if (obs_dn3 !== 1'b1 || obs_rdy3 !== 1'b1) begin n_fail++; $display("FAIL single_done: got done=%b in_ready=%b exp 1/1", obs_dn3, obs_rdy3); end
    n_tests++; if (err !== 1'b0 || wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL single_err_count: got err=%b wr_count=%0d exp 0/%0d", err, wr_count, exp_cnt); end
    n_tests++; if (u_arr.mem_q[2] !== mem_model[2]) begin n_fail++; $display("FAIL single_array: got %h exp %h", u_arr.mem_q[2], mem_model[2]); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b exp 0", done); end
  endtask

  task automatic test_fill();
    logic [N-1:0] pat;
    logic [M-1:0] idx;
    int dones, bad_rdy, bad_we;
    pat = 4'h5; dones = 0; bad_rdy = 0; bad_we = 0;
    fill_data = pat; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      idx = M'(c / 2);
      if (in_ready !== 1'b0) bad_rdy++;
      if ((c % 2 == 0) && (wrt_enab !== 1'b1 || wadd !== idx || d_in !== pat)) bad_we++;
      if ((c % 2 == 1) && wrt_enab !== 1'b0) bad_we++;
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    for (int i = 0; i < WORDS; i++) model_op(M'(i), pat, pat, 1'b0);
    n_tests++; if (dones != WORDS) begin n_fail++; $display("FAIL fill_done_pulses: got %0d exp %0d", dones, WORDS); end
    n_tests++; if (bad_rdy != 0) begin n_fail++; $display("FAIL fill_ready_low: got %0d cycles with in_ready!=0 exp 0", bad_rdy); end
    n_tests++; if (bad_we != 0) begin n_fail++; $display("FAIL fill_write_beats: got %0d bad cycles exp 0", bad_we); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_end_ready: got %b exp 1", in_ready); end
    n_tests++; if (wr_count !== 8'(exp_cnt) || err !== exp_err) begin n_fail++; $display("FAIL fill_count_err: got cnt=%0d err=%b exp %0d/%b", wr_count, err, exp_cnt, exp_err); end
    for (int i = 0; i < WORDS; i++) begin
      n_tests++; if (u_arr.mem_q[i] !== mem_model[i]) begin n_fail++; $display("FAIL fill_array[%0d]: got %h exp %h", i, u_arr.mem_q[i], mem_model[i]); end
    end
  endtask

  task automatic test_mismatch();
    run_req(2'd1, 4'hC, 1'b1, 4'h3, 1'b0);
    model_op(2'd1, 4'hC, 4'h3, 1'b0);
    n_tests++; if (err !== exp_err || err_addr !== exp_err_addr) begin n_fail++; $display("FAIL mismatch_first: got err=%b err_addr=%h exp %b/%h", err, err_addr, exp_err, exp_err_addr); end
    n_tests++; if (obs_dn3 !== 1'b1) begin n_fail++; $display("FAIL mismatch_done: got %b exp 1", obs_dn3); end
    run_req(2'd3, 4'h7, 1'b1, 4'h3, 1'b0);
    model_op(2'd3, 4'h7, 4'h3, 1'b0);
    n_tests++; if (err !== exp_err || err_addr !== exp_err_addr) begin n_fail++; $display("FAIL mismatch_second_keeps_addr: got err=%b err_addr=%h exp %b/%h", err, err_addr, exp_err, exp_err_addr); end
  endtask

  task automatic test_err_clr_collision();
    run_req(2'd2, 4'h9, 1'b1, 4'h1, 1'b1);
    model_op(2'd2, 4'h9, 4'h1, 1'b1);
    n_tests++; if (err !== exp_err || err_addr !== exp_err_addr) begin n_fail++; $display("FAIL errclr_collision: got err=%b err_addr=%h exp %b/%h", err, err_addr, exp_err, exp_err_addr); end
    run_req(2'd0, 4'h4, 1'b0, '0, 1'b1);
    model_op(2'd0, 4'h4, 4'h4, 1'b1);
    n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL errclr_plain: got err=%b exp %b", err, exp_err); end
  endtask

  task automatic test_priority();
    int bad_rdy, bad_data;
    bad_rdy = 0; bad_data = 0;
    in_valid = 1'b1; in_addr = 2'd3; in_data = 4'h6;
    fill_start = 1'b1; fill_data = 4'hE;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready_with_fill_start: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    fill_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (in_ready !== 1'b0) bad_rdy++;
      if (wrt_enab === 1'b1 && d_in !== 4'hE) bad_data++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < WORDS; i++) model_op(M'(i), 4'hE, 4'hE, 1'b0);
    n_tests++; if (bad_rdy != 0 || bad_data != 0) begin n_fail++; $display("FAIL prio_fill_first: got %0d ready-high and %0d bad-data cycles exp 0/0", bad_rdy, bad_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready_after_fill: got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (wrt_enab !== 1'b1 || wadd !== 2'd3 || d_in !== 4'h6) begin n_fail++; $display("FAIL prio_pending_request: got we=%b wadd=%h d_in=%h exp 1/3/6", wrt_enab, wadd, d_in); end
    repeat (2) @(posedge clk);
    #1;
    model_op(2'd3, 4'h6, 4'h6, 1'b0);
    n_tests++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL prio_count: got %0d exp %0d", wr_count, exp_cnt); end
    for (int i = 0; i < WORDS; i++) begin
      n_tests++; if (u_arr.mem_q[i] !== mem_model[i]) begin n_fail++; $display("FAIL prio_array[%0d]: got %h exp %h", i, u_arr.mem_q[i], mem_model[i]); end
    end
  endtask

  task automatic test_reset_mid_fill();
    fill_data = 4'h9; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (dbg_state !== ST_FILL_WR || wadd !== 2'd2) begin n_fail++; $display("FAIL midfill_position: got state=%0d wadd=%h exp FILL_WR/2", dbg_state, wadd); end
    clr = 1'b0;
    #1;
    model_reset();
    n_tests++; if ({wrt_enab, done, err} !== 3'b000 || {wadd, radd, d_in, err_addr} !== '0) begin n_fail++; $display("FAIL midfill_async_clear: got we=%b done=%b err=%b wadd=%h radd=%h d_in=%h err_addr=%h exp all 0", wrt_enab, done, err, wadd, radd, d_in, err_addr); end
    n_tests++; if (wr_count !== 8'd0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midfill_count_state: got cnt=%0d state=%0d exp 0/IDLE", wr_count, dbg_state); end
    @(posedge clk); #1;
    clr = 1'b1;
    n_tests++; if (in_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL midfill_recovery: got in_ready=%b done=%b exp 1/0", in_ready, done); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0 || wrt_enab !== 1'b0 || u_arr.mem_q[2] !== mem_model[2]) begin n_fail++; $display("FAIL midfill_abandoned: got done=%b we=%b mem[2]=%h exp 0/0/%h", done, wrt_enab, u_arr.mem_q[2], mem_model[2]); end
  endtask

  task automatic test_random_saturation();
    logic [M-1:0] a;
    logic [N-1:0] d, fv, rd, exp_d;
    bit fen, ec;
    for (int k = 0; k < 300; k++) begin
      a = M'($urandom_range(0, WORDS - 1));
      d = N'($urandom_range(0, (1 << N) - 1));
      fen = ($urandom_range(0, 3) == 0);
      ec = ($urandom_range(0, 3) == 0);
      fv = N'($urandom_range(0, (1 << N) - 1));
      exp_q.push_back(d);
      run_req(a, d, fen, fv, ec);
      if (!hs_ok) break;
      rd = fen ? fv : d;
      model_op(a, d, rd, ec);
      exp_d = exp_q.pop_front();
      n_tests++; if (obs_we1 !== 1'b1 || obs_wa1 !== a || obs_di1 !== exp_d) begin n_fail++; $display("FAIL rand_write[%0d]: got we=%b wadd=%h d_in=%h exp 1/%h/%h", k, obs_we1, obs_wa1, obs_di1, a, exp_d); end
      n_tests++; if (obs_dn3 !== 1'b1) begin n_fail++; $display("FAIL rand_done[%0d]: got %b exp 1", k, obs_dn3); end
      n_tests++; if (err !== exp_err || err_addr !== exp_err_addr) begin n_fail++; $display("FAIL rand_err[%0d]: got err=%b err_addr=%h exp %b/%h", k, err, err_addr, exp_err, exp_err_addr); end
      n_tests++; if (u_arr.mem_q[a] !== mem_model[a]) begin n_fail++; $display("FAIL rand_array[%0d]: got %h exp %h", k, u_arr.mem_q[a], mem_model[a]); end
      n_tests++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d exp %0d", k, wr_count, exp_cnt); end
    end
    n_tests++; if (wr_count !== 8'd255) begin n_fail++; $display("FAIL saturation: got %0d exp 255", wr_count); end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem_model[i] = '0;
    test_reset();
    test_single_write();
    test_fill();
    test_mismatch();
    test_err_clr_collision();
    test_priority();
    test_reset_mid_fill();
    test_random_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
